pushbutton_conditioner: RTL and testbench
=========================================

# pushbutton_conditioner

Input-side conditioner for the Nibbler processor's 4-bit `pushbuttons` port. It synchronizes raw switch inputs, debounces each bit independently with a per-bit state machine, and presents a clean level bus that feeds `uP.pushbuttons` directly. It also keeps sticky per-bit press flags and overrun flags, which the processor clears with a one-cycle read strobe.

## Interface
- `WIDTH`, 4: number of button bits.
- `SYNC_STAGES`, 2: synchronizer flip-flop depth; minimum 2.
- `DEBOUNCE_CYCLES`, 4: number of consecutive sampled edges at the new value needed to accept a change; minimum 1.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `buttons_raw`  in  WIDTH  asynchronous switch inputs.
- `read_ack`  in  1  one-cycle strobe; clears flags captured at that edge.
- `pushbuttons`  out  WIDTH  debounced level; connects to `uP.pushbuttons`.
- `press_flags`  out  WIDTH  sticky flag per bit, set on each accepted 0→1 change.
- `overrun`  out  WIDTH  sticky flag per bit, set when a press arrives while its press flag is already set.
- `event_pending`  out  1  OR-reduction of `press_flags`.

## Operation
- **Synchronizer:** a `SYNC_STAGES`-deep shift register per bit. Its last stage is `s[i]`. Only `s[i]` feeds the FSM.
- **Per-bit FSM:** states STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW, with a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - STABLE_LOW, s=1: counter is loaded with 1. If DEBOUNCE_CYCLES==1, go directly to STABLE_HIGH; otherwise go to CHK_HIGH.
  - CHK_HIGH, s=0: return to STABLE_LOW and clear the counter.
  - CHK_HIGH, s=1: increment the counter. When the incremented value equals DEBOUNCE_CYCLES, go to STABLE_HIGH.
  - STABLE_HIGH and CHK_LOW mirror the above with the polarity inverted.
  - `pushbuttons[i]` is 1 in STABLE_HIGH and CHK_LOW, and 0 in STABLE_LOW and CHK_HIGH. It is registered, not decoded combinationally from the next state.
- **Press event:** an event is the edge on which the FSM enters STABLE_HIGH from below. There is no event for a release.
- **Flag update at each edge, per bit:**
  - If an event occurs and `press_flags[i]` is already 1 and `read_ack` is 0, set `overrun[i]`.
  - If `read_ack` is 1, clear `press_flags[i]` and `overrun[i]`. If an event occurs on the same edge, set `press_flags[i]` anyway. Set wins over clear, so a press is never lost, and `overrun` stays 0.
  - If an event occurs and `read_ack` is 0, set `press_flags[i]`.
- **Independence:** bits are fully independent. Simultaneous events on several bits all register on the same edge.
- **Reset asserted (any time, including mid-debounce):**
  - Synchronizers, counters, `pushbuttons`, `press_flags`, `overrun` and `event_pending` are all forced to 0, and every FSM goes to STABLE_LOW.
  - Any partial debounce is discarded.
  - A button that is held through reset release is re-debounced and generates one press event.

## Timing
- Let k be the first rising edge that captures the new raw value. `pushbuttons[i]` changes at edge k + SYNC_STAGES + DEBOUNCE_CYCLES − 1. With the default parameters this is k+5.
- `press_flags[i]` and `event_pending` rise on the same edge as `pushbuttons[i]`.
- **Glitch rejection:**
  - A raw pulse whose synchronized image lasts fewer than DEBOUNCE_CYCLES edges never changes `pushbuttons`.
  - Every bounce restarts the count from 1.
- **Clearing flags:** `read_ack` sampled high at edge n clears the flags after edge n. This is a single-edge action, and holding `read_ack` high has no further effect.
- **Reset:** outputs go to 0 asynchronously on the falling edge of `reset`. The first synchronizer capture occurs on the first clock edge after `reset` returns high.
- **Throughput:** the minimum accepted press-release-press period is 2·DEBOUNCE_CYCLES edges.

## Test plan
- **Reset values:** clock 10 ns, `reset`=0 from 0 to 2 ns, `buttons_raw`=4'b0000 → all outputs are 0 during reset and remain 0 afterwards.
- **Clean press:** `buttons_raw`=4'b1100 applied before edge k, held → `pushbuttons`=4'b1100 and `press_flags`=4'b1100 at edge k+5, `event_pending`=1, `overrun`=0.
- **Bounce:** bit0 toggles 1,0,1,0 on successive cycles, then stays 1 → `pushbuttons[0]` rises exactly 5 edges after the final 0→1 capture. Exactly one press event is recorded.
- **Overrun and clear:**
  - Press bit2, release it, press it again with no `read_ack` → `overrun`=4'b0100.
  - Then pulse `read_ack` for one cycle → `press_flags`=0 and `overrun`=0 on the next edge.
- **Set/clear collision:** `read_ack` asserted on the same edge that bit3 is accepted → `press_flags[3]`=1 and `overrun[3]`=0 after that edge.
- **Reset mid-debounce:** `reset` asserted at count 2 while `buttons_raw`=4'b0001 is held → outputs are 0 immediately. After release, `pushbuttons[0]` rises 5 edges after the first post-reset capture edge, with one press event.

Source files
------------

// File: rtl/pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_conditioner
// Description : Synchronizes, debounces and flags the Nibbler pushbutton bus.
//               Each bit has its own synchronizer and debounce FSM; sticky
//               press/overrun flags are cleared by a one-cycle read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_raw,
  input  logic             read_ack,
  output logic [WIDTH-1:0] pushbuttons,
  output logic [WIDTH-1:0] press_flags,
  output logic [WIDTH-1:0] overrun,
  output logic             event_pending
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_CHK_HIGH    = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_CHK_LOW     = 2'd3
  } db_state_e;

  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] press_event;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] press_flags_q, press_flags_d;
  logic [WIDTH-1:0] overrun_q, overrun_d;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_q;
      db_state_e              state_q, state_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic [CNT_W-1:0]       cnt_inc;
      logic                   bit_level_q;
      logic                   bit_level_d;
      logic                   bit_event;

      // Shift the raw switch level through the synchronizer chain.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], buttons_raw[gi]};
        end
      end

      assign sync_last[gi] = sync_q[SYNC_STAGES-1];
      assign cnt_inc       = cnt_q + C_CNT_ONE;

      // Debounce state, run counter and the registered clean level.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state_q     <= ST_STABLE_LOW;
          cnt_q       <= '0;
          bit_level_q <= 1'b0;
        end else begin
          state_q     <= state_d;
          cnt_q       <= cnt_d;
          bit_level_q <= bit_level_d;
        end
      end

      // Next state: a change is accepted after DEBOUNCE_CYCLES consecutive
      // samples at the new value; any sample at the old value restarts it.
      always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_level_d = 1'b0;
        bit_event   = 1'b0;
        case (state_q)
          ST_STABLE_LOW: begin
            if (sync_last[gi]) begin
              cnt_d   = C_CNT_ONE;
              state_d = (DEBOUNCE_CYCLES == 1) ? ST_STABLE_HIGH : ST_CHK_HIGH;
            end
          end
          ST_CHK_HIGH: begin
            if (!sync_last[gi]) begin
              state_d = ST_STABLE_LOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == C_CNT_LAST) begin
                state_d = ST_STABLE_HIGH;
              end
            end
          end
          ST_STABLE_HIGH: begin
            if (!sync_last[gi]) begin
              cnt_d   = C_CNT_ONE;
              state_d = (DEBOUNCE_CYCLES == 1) ? ST_STABLE_LOW : ST_CHK_LOW;
            end
          end
          ST_CHK_LOW: begin
            if (sync_last[gi]) begin
              state_d = ST_STABLE_HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == C_CNT_LAST) begin
                state_d = ST_STABLE_LOW;
              end
            end
          end
          default: begin
            state_d = ST_STABLE_LOW;
            cnt_d   = '0;
          end
        endcase
        bit_level_d = (state_d == ST_STABLE_HIGH) || (state_d == ST_CHK_LOW);
        // Only an entry into STABLE_HIGH from the low side is a press;
        // returning from CHK_LOW is just a rejected release bounce.
        bit_event   = (state_d == ST_STABLE_HIGH) &&
                      ((state_q == ST_STABLE_LOW) || (state_q == ST_CHK_HIGH));
      end

      assign level_q[gi]     = bit_level_q;
      assign press_event[gi] = bit_event;
    end
  endgenerate

  // Flag update: a press on the same edge as read_ack survives the clear.
  always_comb begin
    press_flags_d = press_flags_q | press_event;
    overrun_d     = overrun_q | (press_event & press_flags_q);
    if (read_ack) begin
      press_flags_d = press_event;
      overrun_d     = '0;
    end
  end

  // Sticky press and overrun flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      press_flags_q <= '0;
      overrun_q     <= '0;
    end else begin
      press_flags_q <= press_flags_d;
      overrun_q     <= overrun_d;
    end
  end

  assign pushbuttons   = level_q;
  assign press_flags   = press_flags_q;
  assign overrun       = overrun_q;
  assign event_pending = |press_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pushbutton_conditioner
// Description : Directed scenarios plus random button activity, compared
//               against a window-based reference model of the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pushbutton_conditioner;

  localparam int          WIDTH    = 4;
  localparam int          SYNC     = 2;
  localparam int          DEB      = 4;
  localparam logic [63:0] WIN_MASK = (64'd1 << DEB) - 64'd1;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] buttons_raw;
  logic             read_ack;
  logic [WIDTH-1:0] pushbuttons;
  logic [WIDTH-1:0] press_flags;
  logic [WIDTH-1:0] overrun;
  logic             event_pending;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  pushbutton_conditioner #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buttons_raw  (buttons_raw),
    .read_ack     (read_ack),
    .pushbuttons  (pushbuttons),
    .press_flags  (press_flags),
    .overrun      (overrun),
    .event_pending(event_pending)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] pb,
                            input logic [WIDTH-1:0] pf, input logic [WIDTH-1:0] ov,
                            input logic ep);
    check_val({tag, "_pushbuttons"},   32'(pushbuttons),   32'(pb));
    check_val({tag, "_press_flags"},   32'(press_flags),   32'(pf));
    check_val({tag, "_overrun"},       32'(overrun),       32'(ov));
    check_val({tag, "_event_pending"}, 32'(event_pending), 32'(ep));
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model: raw samples are delayed SYNC edges, then a level flips
  // once the most recent DEB delayed samples all disagree with it.
  logic [SYNC-1:0]  m_pipe [WIDTH] = '{default: '0};
  logic [63:0]      m_hist [WIDTH] = '{default: '0};
  logic [WIDTH-1:0] m_level = '0;
  logic [WIDTH-1:0] m_press = '0;
  logic [WIDTH-1:0] m_ovr   = '0;
  logic [63:0]      t_hist;
  logic             t_ev;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_pipe[i] <= '0;
        m_hist[i] <= '0;
      end
      m_level <= '0;
      m_press <= '0;
      m_ovr   <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        m_pipe[i] <= {m_pipe[i][SYNC-2:0], buttons_raw[i]};
        t_hist    = {m_hist[i][62:0], m_pipe[i][SYNC-1]};
        m_hist[i] <= t_hist;
        t_ev      = 1'b0;
        if (!m_level[i] && ((t_hist & WIN_MASK) == WIN_MASK)) begin
          m_level[i] <= 1'b1;
          t_ev       = 1'b1;
        end else if (m_level[i] && ((t_hist & WIN_MASK) == 64'd0)) begin
          m_level[i] <= 1'b0;
        end
        if (read_ack) begin
          m_press[i] <= t_ev;
          m_ovr[i]   <= 1'b0;
        end else if (t_ev) begin
          m_press[i] <= 1'b1;
          if (m_press[i]) m_ovr[i] <= 1'b1;
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) check_outs("model", m_level, m_press, m_ovr, |m_press);
  end

  int hold [WIDTH];

  initial begin
    reset       = 1'b0;
    buttons_raw = '0;
    read_ack    = 1'b0;
    #1;
    check_outs("in_reset", '0, '0, '0, 1'b0);
    #1 reset = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;
    wait_neg(3);
    check_outs("rst_idle", '0, '0, '0, 1'b0);

    // Clean press of bits 3:2.
    buttons_raw = 4'b1100;
    wait_neg(5);
    check_val("press_k4_pushbuttons", 32'(pushbuttons), 32'h0);
    wait_neg(1);
    check_outs("press_k5", 4'b1100, 4'b1100, 4'b0000, 1'b1);
    buttons_raw = 4'b0000;
    wait_neg(10);
    read_ack = 1'b1;
    wait_neg(1);
    read_ack = 1'b0;
    check_val("clear1_press_flags", 32'(press_flags), 32'h0);

    // Bouncing bit 0: 1,0,1,0 then held.
    buttons_raw = 4'b0001; wait_neg(1);
    buttons_raw = 4'b0000; wait_neg(1);
    buttons_raw = 4'b0001; wait_neg(1);
    buttons_raw = 4'b0000; wait_neg(1);
    buttons_raw = 4'b0001;
    wait_neg(5);
    check_val("bounce_k4_pushbuttons", 32'(pushbuttons), 32'h0);
    wait_neg(1);
    check_outs("bounce_k5", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    wait_neg(10);
    check_outs("bounce_hold", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    buttons_raw = 4'b0000;
    wait_neg(10);
    read_ack = 1'b1;
    wait_neg(1);
    read_ack = 1'b0;

    // Press / release / press of bit 2 without acknowledgement.
    buttons_raw = 4'b0100; wait_neg(8);
    buttons_raw = 4'b0000; wait_neg(8);
    buttons_raw = 4'b0100; wait_neg(8);
    check_outs("overrun", 4'b0100, 4'b0100, 4'b0100, 1'b1);
    read_ack = 1'b1;
    wait_neg(1);
    read_ack = 1'b0;
    check_outs("overrun_clr", 4'b0100, 4'b0000, 4'b0000, 1'b0);

    // Bit 3 accepted on the same edge read_ack is sampled.
    buttons_raw = 4'b1100;
    wait_neg(5);
    check_val("collide_k4_pushbuttons", 32'(pushbuttons), 32'h4);
    read_ack = 1'b1;
    wait_neg(1);
    read_ack = 1'b0;
    check_outs("collide", 4'b1100, 4'b1000, 4'b0000, 1'b1);

    // Reset while bit 0 is mid-debounce (count 2), bits 3:2 held.
    buttons_raw = 4'b1101;
    wait_neg(4);
    #2 reset = 1'b0;
    #1 check_outs("rst_async", '0, '0, '0, 1'b0);
    wait_neg(2);
    check_outs("rst_hold", '0, '0, '0, 1'b0);
    reset = 1'b1;
    wait_neg(5);
    check_val("rerun_k4_pushbuttons", 32'(pushbuttons), 32'h0);
    wait_neg(1);
    check_outs("rerun_k5", 4'b1101, 4'b1101, 4'b0000, 1'b1);

    // Random activity: hold times of 1..9 edges mix glitches and presses.
    for (int i = 0; i < WIDTH; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ((c % 700) == 350) begin
        #3 reset = 1'b0;
        #1 check_outs("rnd_rst", '0, '0, '0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (hold[i] == 0) begin
          buttons_raw[i] = ~buttons_raw[i];
          hold[i]        = int'($urandom_range(1, 9));
        end else begin
          hold[i] = hold[i] - 1;
        end
      end
      read_ack = ($urandom_range(0, 7) == 0);
    end
    read_ack = 1'b0;
    wait_neg(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
